// File: rtl/overlay_pkg.sv
// Shared types, colour helper and seven-segment glyph geometry
// for the pipelined VGA overlay mixer.
package overlay_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_TRACK  = 3'd1,
    ST_ARMING = 3'd2,
    ST_LOCKED = 3'd3,
    ST_COAST  = 3'd4
  } lock_st_e;

  localparam int GLYPH_W     = 8;
  localparam int GLYPH_H     = 16;
  localparam int SEG_T       = 2;
  localparam int DIG_PITCH   = 20;
  localparam int TXT_ROW_GAP = 40;
  localparam int NUM_DIG     = 3;

  function automatic logic [31:0] chan_full(
    input int unsigned w
  );
    return (32'd1 << w) - 32'd1;
  endfunction

  // {a,b,c,d,e,f,g}
  function automatic logic [6:0] seg7(
    input logic [3:0] d
  );
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // ox/oy are scaled offsets already known to lie inside the cell
  function automatic logic glyph_hit(
    input logic [6:0] seg,
    input int         ox,
    input int         oy,
    input int         sc
  );
    logic top, bot, mid, lft, rgt, upr;
    top = oy < SEG_T * sc;
    bot = oy >= (GLYPH_H - SEG_T) * sc;
    mid = (oy >= (GLYPH_H / 2 - 1) * sc)
       && (oy < (GLYPH_H / 2 + 1) * sc);
    lft = ox < SEG_T * sc;
    rgt = ox >= (GLYPH_W - SEG_T) * sc;
    upr = oy < (GLYPH_H / 2) * sc;
    return (seg[6] & top)
         | (seg[5] & rgt & upr)
         | (seg[4] & rgt & ~upr)
         | (seg[3] & bot)
         | (seg[2] & lft & ~upr)
         | (seg[1] & lft & upr)
         | (seg[0] & mid);
  endfunction

endpackage

// File: rtl/overlay_mixer_pipe_bin2bcd_seq.sv
// Sequential double-dabble converter: COORD_W shift steps
// per start, three BCD digits out with a one-cycle done pulse.
module bin2bcd_seq #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_i,
  input  logic [W-1:0] bin_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [11:0]  bcd_o
);

  localparam int CW = $clog2(W);

  logic [W-1:0]  sh_q, sh_d;
  logic [11:0]   bcd_q, bcd_d, adj;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5)
                    ? bcd_q[4*i +: 4] + 4'd3
                    : bcd_q[4*i +: 4];
    end
  end

  always_comb begin
    sh_d   = sh_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start_i) begin
      sh_d   = bin_i;
      bcd_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      sh_d  = {sh_q[W-2:0], 1'b0};
      bcd_d = {adj[10:0], sh_q[W-1]};
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(W - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/overlay_mixer_pipe.sv
// Per-frame snapshotted overlay: lock FSM, BCD readout and a
// two-stage hit/colour pipeline in front of the VGA pins.
module overlay_mixer_pipe
  import overlay_pkg::*;
#(
  parameter int COLOR_W     = 4,
  parameter int COORD_W     = 10,
  parameter int CTR_X0      = 288,
  parameter int CTR_X1      = 351,
  parameter int CTR_Y0      = 208,
  parameter int CTR_Y1      = 271,
  parameter int AIM_LEN     = 10,
  parameter int AIM_THK     = 1,
  parameter int DIG_SCALE   = 2,
  parameter int TXT_X0      = 10,
  parameter int TXT_Y0      = 10,
  parameter int LOCK_FRAMES = 8,
  parameter int LOST_FRAMES = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_start,
  input  logic                 de_in,
  input  logic [COORD_W-1:0]   x_pixel,
  input  logic [COORD_W-1:0]   y_pixel,
  input  logic [3*COLOR_W-1:0] img_bg,
  input  logic [COORD_W-1:0]   aim_x,
  input  logic [COORD_W-1:0]   aim_y,
  input  logic                 aim_detected,
  input  logic [COORD_W-1:0]   box_x_min,
  input  logic [COORD_W-1:0]   box_x_max,
  input  logic [COORD_W-1:0]   box_y_min,
  input  logic [COORD_W-1:0]   box_y_max,
  output logic [COLOR_W-1:0]   r_port,
  output logic [COLOR_W-1:0]   g_port,
  output logic [COLOR_W-1:0]   b_port,
  output logic                 de_out,
  output logic [2:0]           lock_state,
  output logic                 locked
);

  localparam int CNT_W = $clog2(
    LOST_FRAMES > LOCK_FRAMES ? LOST_FRAMES : LOCK_FRAMES);
  localparam int PW = 3 * COLOR_W;
  localparam int DW = 4 * NUM_DIG;

  typedef logic [COORD_W-1:0] crd_t;

  localparam crd_t CX0  = COORD_W'(CTR_X0);
  localparam crd_t CX1  = COORD_W'(CTR_X1);
  localparam crd_t CY0  = COORD_W'(CTR_Y0);
  localparam crd_t CY1  = COORD_W'(CTR_Y1);
  localparam crd_t LEN  = COORD_W'(AIM_LEN);
  localparam crd_t THK  = COORD_W'(AIM_THK);
  localparam crd_t MAXC = '1;

  localparam logic [COLOR_W-1:0] FULL =
    COLOR_W'(chan_full(COLOR_W));
  localparam logic [COLOR_W-1:0] NONE = '0;
  localparam logic [PW-1:0] C_RED   = {FULL, NONE, NONE};
  localparam logic [PW-1:0] C_GREEN = {NONE, FULL, NONE};
  localparam logic [PW-1:0] C_BLUE  = {NONE, NONE, FULL};
  localparam logic [PW-1:0] C_WHITE = {FULL, FULL, FULL};

  function automatic crd_t sat_sub(input crd_t v, input crd_t d);
    return (v >= d) ? v - d : '0;
  endfunction

  function automatic crd_t sat_add(input crd_t v, input crd_t d);
    return (v > MAXC - d) ? MAXC : v + d;
  endfunction

  function automatic logic dig_hit(
    input crd_t       px,
    input crd_t       py,
    input int         ox0,
    input int         oy0,
    input logic [3:0] dig
  );
    crd_t dx, dy;
    dx = px - COORD_W'(ox0);
    dy = py - COORD_W'(oy0);
    if (px < COORD_W'(ox0) || py < COORD_W'(oy0))
      return 1'b0;
    if (int'(dx) >= GLYPH_W * DIG_SCALE ||
        int'(dy) >= GLYPH_H * DIG_SCALE)
      return 1'b0;
    return glyph_hit(seg7(dig), int'(dx), int'(dy), DIG_SCALE);
  endfunction

  lock_st_e         st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       fcnt_q;
  crd_t             ax_q, ay_q;
  crd_t             bx0_q, bx1_q, by0_q, by1_q;
  logic             in_win;

  assign in_win = aim_x >= CX0 && aim_x <= CX1
               && aim_y >= CY0 && aim_y <= CY1;

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    if (frame_start) begin
      unique case (st_q)
        ST_IDLE: begin
          if (aim_detected) st_d = ST_TRACK;
        end
        ST_TRACK: begin
          if (!aim_detected) begin
            st_d  = ST_COAST;
            cnt_d = '0;
          end else if (in_win) begin
            st_d  = ST_ARMING;
            cnt_d = CNT_W'(1);
          end
        end
        ST_ARMING: begin
          if (!aim_detected) begin
            st_d  = ST_COAST;
            cnt_d = '0;
          end else if (!in_win) begin
            st_d  = ST_TRACK;
            cnt_d = '0;
          end else if (cnt_q == CNT_W'(LOCK_FRAMES - 1)) begin
            st_d  = ST_LOCKED;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_LOCKED: begin
          if (!aim_detected) begin
            st_d  = ST_COAST;
            cnt_d = '0;
          end else if (!in_win) begin
            st_d  = ST_TRACK;
          end
        end
        ST_COAST: begin
          if (aim_detected) begin
            st_d  = ST_TRACK;
            cnt_d = '0;
          end else if (cnt_q == CNT_W'(LOST_FRAMES - 1)) begin
            st_d  = ST_IDLE;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          st_d  = ST_IDLE;
          cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q   <= ST_IDLE;
      cnt_q  <= '0;
      fcnt_q <= '0;
      ax_q   <= '0;
      ay_q   <= '0;
      bx0_q  <= '0;
      bx1_q  <= '0;
      by0_q  <= '0;
      by1_q  <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      if (frame_start) begin
        fcnt_q <= fcnt_q + 1'b1;
        bx0_q  <= box_x_min;
        bx1_q  <= box_x_max;
        by0_q  <= box_y_min;
        by1_q  <= box_y_max;
        // coasting keeps the last valid aim on screen
        if (st_d != ST_COAST) begin
          ax_q <= aim_x;
          ay_q <= aim_y;
        end
      end
    end
  end

  logic          go_q, ph_q;
  logic [DW-1:0] tx_q, dx_q, dy_q;
  logic          cv_start, cv_busy, cv_done;
  logic [DW-1:0] cv_bcd;
  crd_t          cv_bin;

  assign cv_start = go_q | (cv_done & ~ph_q & ~cv_busy);
  assign cv_bin   = go_q ? ax_q : ay_q;

  bin2bcd_seq #(.W(COORD_W)) u_bcd (
    .clk     (clk),
    .reset   (reset),
    .start_i (cv_start),
    .bin_i   (cv_bin),
    .busy_o  (cv_busy),
    .done_o  (cv_done),
    .bcd_o   (cv_bcd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      go_q <= 1'b0;
      ph_q <= 1'b0;
      tx_q <= '0;
      dx_q <= '0;
      dy_q <= '0;
    end else begin
      go_q <= frame_start;
      if (go_q) begin
        ph_q <= 1'b0;
      end else if (cv_done && !ph_q) begin
        ph_q <= 1'b1;
        tx_q <= cv_bcd;
      end else if (cv_done && ph_q) begin
        ph_q <= 1'b0;
        dx_q <= tx_q;
        dy_q <= cv_bcd;
      end
    end
  end

  crd_t hx_lo, hx_hi, hy_lo, hy_hi;
  crd_t vx_lo, vx_hi, vy_lo, vy_hi;
  logic cen_h, crs_h, box_h, txt_h;

  assign hx_lo = sat_sub(ax_q, LEN);
  assign hx_hi = sat_add(ax_q, LEN);
  assign hy_lo = sat_sub(ay_q, THK);
  assign hy_hi = sat_add(ay_q, THK);
  assign vx_lo = sat_sub(ax_q, THK);
  assign vx_hi = sat_add(ax_q, THK);
  assign vy_lo = sat_sub(ay_q, LEN);
  assign vy_hi = sat_add(ay_q, LEN);

  assign cen_h =
      ((x_pixel == CX0 || x_pixel == CX1)
        && y_pixel >= CY0 && y_pixel <= CY1)
    || ((y_pixel == CY0 || y_pixel == CY1)
        && x_pixel >= CX0 && x_pixel <= CX1);

  assign crs_h =
      (x_pixel >= hx_lo && x_pixel <= hx_hi
        && y_pixel >= hy_lo && y_pixel <= hy_hi)
    || (x_pixel >= vx_lo && x_pixel <= vx_hi
        && y_pixel >= vy_lo && y_pixel <= vy_hi);

  assign box_h =
      ((x_pixel == bx0_q || x_pixel == bx1_q)
        && y_pixel >= by0_q && y_pixel <= by1_q)
    || ((y_pixel == by0_q || y_pixel == by1_q)
        && x_pixel >= bx0_q && x_pixel <= bx1_q);

  always_comb begin
    txt_h = 1'b0;
    for (int k = 0; k < NUM_DIG; k++) begin
      txt_h = txt_h
        | dig_hit(x_pixel, y_pixel,
                  TXT_X0 + k * DIG_PITCH, TXT_Y0,
                  dx_q[4*(NUM_DIG-1-k) +: 4])
        | dig_hit(x_pixel, y_pixel,
                  TXT_X0 + k * DIG_PITCH,
                  TXT_Y0 + TXT_ROW_GAP,
                  dy_q[4*(NUM_DIG-1-k) +: 4]);
    end
  end

  logic          cen1_q, crs1_q, box1_q, txt1_q, de1_q;
  logic [PW-1:0] bg1_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cen1_q <= 1'b0;
      crs1_q <= 1'b0;
      box1_q <= 1'b0;
      txt1_q <= 1'b0;
      de1_q  <= 1'b0;
      bg1_q  <= '0;
    end else begin
      cen1_q <= cen_h;
      crs1_q <= crs_h;
      box1_q <= box_h;
      txt1_q <= txt_h;
      de1_q  <= de_in;
      bg1_q  <= img_bg;
    end
  end

  logic          crs_en, box_en, txt_en;
  logic [PW-1:0] crs_col, col_d, col_q;
  logic          de2_q;

  always_comb begin
    crs_en  = 1'b0;
    crs_col = C_RED;
    unique case (st_q)
      ST_TRACK, ST_ARMING: crs_en = 1'b1;
      ST_LOCKED: begin
        crs_en  = 1'b1;
        crs_col = C_WHITE;
      end
      ST_COAST: crs_en = ~fcnt_q[3];
      default:  crs_en = 1'b0;
    endcase
    box_en = (st_q == ST_TRACK) || (st_q == ST_ARMING);
    txt_en = (st_q != ST_IDLE);
    col_d  = '0;
    if (de1_q) begin
      if (txt1_q && txt_en)      col_d = C_GREEN;
      else if (box1_q && box_en) col_d = C_GREEN;
      else if (crs1_q && crs_en) col_d = crs_col;
      else if (cen1_q)           col_d = C_BLUE;
      else                       col_d = bg1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q <= '0;
      de2_q <= 1'b0;
    end else begin
      col_q <= col_d;
      de2_q <= de1_q;
    end
  end

  assign r_port     = col_q[PW-1 -: COLOR_W];
  assign g_port     = col_q[2*COLOR_W-1 -: COLOR_W];
  assign b_port     = col_q[COLOR_W-1:0];
  assign de_out     = de2_q;
  assign lock_state = st_q;
  assign locked     = (st_q == ST_LOCKED);

endmodule
